// File: rtl/fwd_hazard_if.sv
// Pipeline <-> forwarding/hazard unit bundle: operand sources, hazard inputs, resolved results.
// Statistics signals exist only when FWD_STATS_EN is defined.
interface fwd_hazard_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 16
);
    logic [NPORTS-1:0][REG_AW-1:0] id_src;
    logic [NPORTS-1:0]             id_src_vld;
    logic [NPORTS-1:0][REG_AW-1:0] ex_src;
    logic [NPORTS-1:0]             ex_src_vld;
    logic [NPORTS-1:0][DATA_W-1:0] ex_rf_data;
    logic [REG_AW-1:0]             ex_dst;
    logic                          ex_wr;
    logic                          ex_mem_rd;
    logic [REG_AW-1:0]             em_dst;
    logic                          em_wr;
    logic                          em_mem_rd;
    logic [DATA_W-1:0]             em_alu;
    logic [REG_AW-1:0]             mw_dst;
    logic                          mw_wr;
    logic [DATA_W-1:0]             mw_data;
    logic                          mem_busy;
    logic [NPORTS-1:0][DATA_W-1:0] ex_opnd;
    logic [NPORTS-1:0][1:0]        fwd_sel;
    logic                          stall_fd;
    logic                          bubble_ex;
    logic                          hold_ex;
`ifdef FWD_STATS_EN
    logic [CNT_W-1:0]              stat_lu;
    logic [CNT_W-1:0]              stat_hold;
`else
    logic [CNT_W-1:0]              unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    modport master (
        output id_src, id_src_vld, ex_src, ex_src_vld, ex_rf_data,
               ex_dst, ex_wr, ex_mem_rd, em_dst, em_wr, em_mem_rd, em_alu,
               mw_dst, mw_wr, mw_data, mem_busy,
        input  ex_opnd, fwd_sel, stall_fd, bubble_ex, hold_ex
`ifdef FWD_STATS_EN
        , input stat_lu, stat_hold
`endif
    );

    modport slave (
        input  id_src, id_src_vld, ex_src, ex_src_vld, ex_rf_data,
               ex_dst, ex_wr, ex_mem_rd, em_dst, em_wr, em_mem_rd, em_alu,
               mw_dst, mw_wr, mw_data, mem_busy,
        output ex_opnd, fwd_sel, stall_fd, bubble_ex, hold_ex
`ifdef FWD_STATS_EN
        , output stat_lu, stat_hold
`endif
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and mem_busy operand hold for the 16-bit core.
// Define FWD_STATS_EN to add saturating load-use / hold-cycle counters.
module fwd_hazard_port #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_vld,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [REG_AW-1:0] em_dst,
    input  logic              em_wr,
    input  logic              em_mem_rd,
    input  logic [DATA_W-1:0] em_alu,
    input  logic [REG_AW-1:0] mw_dst,
    input  logic              mw_wr,
    input  logic [DATA_W-1:0] mw_data,
    output logic [DATA_W-1:0] opnd,
    output logic [1:0]        sel
);
    // A load in EX/MEM has no data yet; the load-use bubble puts its consumer a stage later.
    always_comb begin
        opnd = rf_data;
        sel  = 2'b00;
        if (src_vld) begin
            if (em_wr && !em_mem_rd && em_dst == src) begin
                opnd = em_alu;
                sel  = 2'b10;
            end else if (mw_wr && mw_dst == src) begin
                opnd = mw_data;
                sel  = 2'b01;
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 16
) (
    input logic        clk,
    input logic        rst_n,
    fwd_hazard_if.slave bus
);
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [NPORTS-1:0][DATA_W-1:0] hold_q, hold_d;
    logic [NPORTS-1:0][DATA_W-1:0] res_opnd;
    logic [NPORTS-1:0][1:0]        res_sel;
    logic [NPORTS-1:0]             lu_hit;
    logic                          load_use;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_hazard_port #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_port (
            .src      (bus.ex_src[p]),
            .src_vld  (bus.ex_src_vld[p]),
            .rf_data  (bus.ex_rf_data[p]),
            .em_dst   (bus.em_dst),
            .em_wr    (bus.em_wr),
            .em_mem_rd(bus.em_mem_rd),
            .em_alu   (bus.em_alu),
            .mw_dst   (bus.mw_dst),
            .mw_wr    (bus.mw_wr),
            .mw_data  (bus.mw_data),
            .opnd     (res_opnd[p]),
            .sel      (res_sel[p])
        );
        assign lu_hit[p] = bus.id_src_vld[p] && (bus.id_src[p] == bus.ex_dst);
    end

    assign load_use = bus.ex_wr && bus.ex_mem_rd && (|lu_hit);

    always_comb begin
        state_d       = bus.mem_busy ? HOLD : RUN;
        hold_d        = hold_q;
        bus.ex_opnd   = res_opnd;
        bus.fwd_sel   = res_sel;
        bus.hold_ex   = 1'b0;
        bus.stall_fd  = 1'b0;
        bus.bubble_ex = 1'b0;
        if (state_q == RUN && bus.mem_busy)
            hold_d = res_opnd;
        // In reset the forward path stays live but all pipeline control is released.
        if (!rst_n) begin
            bus.hold_ex = 1'b0;
        end else if (state_q == RUN) begin
            bus.hold_ex   = bus.mem_busy;
            bus.stall_fd  = bus.mem_busy || load_use;
            bus.bubble_ex = load_use && !bus.mem_busy;
        end else begin
            // WB keeps retiring while frozen, so EX must see the operands captured on entry.
            bus.ex_opnd  = hold_q;
            bus.fwd_sel  = '1;
            bus.hold_ex  = bus.mem_busy;
            bus.stall_fd = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stat_lu_q, stat_lu_d, stat_hold_q, stat_hold_d;

    always_comb begin
        stat_lu_d   = stat_lu_q;
        stat_hold_d = stat_hold_q;
        if (state_q == RUN && bus.bubble_ex && stat_lu_q != '1)
            stat_lu_d = stat_lu_q + CNT_W'(1);
        if (state_q == HOLD && stat_hold_q != '1)
            stat_hold_d = stat_hold_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_lu_q   <= '0;
            stat_hold_q <= '0;
        end else begin
            stat_lu_q   <= stat_lu_d;
            stat_hold_q <= stat_hold_d;
        end
    end

    assign bus.stat_lu   = stat_lu_q;
    assign bus.stat_hold = stat_hold_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test-plan steps followed by random traffic, checked against a behavioural model.
module tb_fwd_hazard_unit;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int NPORTS = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // model: the unit is frozen iff mem_busy was seen at the last non-reset edge
    bit              prev_busy = 1'b0;
    logic [DATA_W-1:0] saved [NPORTS];
    int              m_lu = 0;
    int              m_hold = 0;

    fwd_hazard_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NPORTS(NPORTS), .CNT_W(CNT_W)) bus_if ();

    fwd_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NPORTS(NPORTS), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_if.id_src     = '0;
        bus_if.id_src_vld = '0;
        bus_if.ex_src     = '0;
        bus_if.ex_src_vld = '0;
        bus_if.ex_rf_data = {16'h1111, 16'h2222};
        bus_if.ex_dst     = '0;
        bus_if.ex_wr      = 1'b0;
        bus_if.ex_mem_rd  = 1'b0;
        bus_if.em_dst     = '0;
        bus_if.em_wr      = 1'b0;
        bus_if.em_mem_rd  = 1'b0;
        bus_if.em_alu     = '0;
        bus_if.mw_dst     = '0;
        bus_if.mw_wr      = 1'b0;
        bus_if.mw_data    = '0;
        bus_if.mem_busy   = 1'b0;
    endtask

    // Check all outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle(input string tag);
        logic [DATA_W-1:0] r_op [NPORTS];
        logic [1:0]        r_sel [NPORTS];
        bit frozen, lu, busy;
        @(negedge clk);
        busy   = bus_if.mem_busy;
        frozen = rst_n && prev_busy;
        lu     = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            r_op[p]  = bus_if.ex_rf_data[p];
            r_sel[p] = 2'd0;
            if (bus_if.ex_src_vld[p] && bus_if.em_wr && !bus_if.em_mem_rd && bus_if.em_dst == bus_if.ex_src[p]) begin
                r_op[p] = bus_if.em_alu; r_sel[p] = 2'd2;
            end else if (bus_if.ex_src_vld[p] && bus_if.mw_wr && bus_if.mw_dst == bus_if.ex_src[p]) begin
                r_op[p] = bus_if.mw_data; r_sel[p] = 2'd1;
            end
            if (bus_if.id_src_vld[p] && bus_if.id_src[p] == bus_if.ex_dst && bus_if.ex_wr && bus_if.ex_mem_rd)
                lu = 1'b1;
        end
        for (int p = 0; p < NPORTS; p++) begin
            chk($sformatf("%s opnd%0d", tag, p), 32'(bus_if.ex_opnd[p]), 32'(frozen ? saved[p] : r_op[p]));
            chk($sformatf("%s sel%0d", tag, p), 32'(bus_if.fwd_sel[p]), 32'(frozen ? 2'd3 : r_sel[p]));
        end
        chk({tag, " hold_ex"}, 32'(bus_if.hold_ex), 32'(rst_n && busy));
        chk({tag, " stall_fd"}, 32'(bus_if.stall_fd), 32'(rst_n && (frozen || busy || lu)));
        chk({tag, " bubble_ex"}, 32'(bus_if.bubble_ex), 32'(rst_n && !frozen && !busy && lu));
`ifdef FWD_STATS_EN
        chk({tag, " stat_lu"}, 32'(bus_if.stat_lu), 32'(m_lu));
        chk({tag, " stat_hold"}, 32'(bus_if.stat_hold), 32'(m_hold));
`endif
        @(posedge clk);
        if (!rst_n) begin
            prev_busy = 1'b0;
            m_lu = 0;
            m_hold = 0;
            for (int p = 0; p < NPORTS; p++) saved[p] = '0;
        end else begin
            if (!frozen && !busy && lu && m_lu < CMAX) m_lu++;
            if (frozen && m_hold < CMAX) m_hold++;
            if (!frozen && busy)
                for (int p = 0; p < NPORTS; p++) saved[p] = r_op[p];
            prev_busy = busy;
        end
        #1;
    endtask

    task automatic load_use_in();
        bus_if.ex_wr         = 1'b1;
        bus_if.ex_mem_rd     = 1'b1;
        bus_if.ex_dst        = 3'd2;
        bus_if.id_src[1]     = 3'd2;
        bus_if.id_src_vld[1] = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < NPORTS; p++) saved[p] = '0;
        rst_n = 1'b0;
        idle();
        #1;
        cycle("reset0");
        cycle("reset1");
        rst_n = 1'b1;
        cycle("idle");

        // EX/MEM beats MEM/WB on the same register
        bus_if.ex_src[0] = 3'd3; bus_if.ex_src_vld = 2'b11;
        bus_if.em_wr = 1'b1; bus_if.em_dst = 3'd3; bus_if.em_alu = 16'h1234;
        bus_if.mw_wr = 1'b1; bus_if.mw_dst = 3'd3; bus_if.mw_data = 16'hBEEF;
        cycle("prio");
        chk("prio_val", 32'(bus_if.ex_opnd[0]), 32'h1234);
        chk("prio_sel", 32'(bus_if.fwd_sel[0]), 32'h2);

        // invalid source never forwards
        idle();
        bus_if.ex_src[1] = 3'd5; bus_if.ex_src_vld = 2'b01;
        bus_if.em_dst = 3'd5; bus_if.em_wr = 1'b1; bus_if.em_alu = 16'h7777;
        cycle("novld");
        chk("novld_val", 32'(bus_if.ex_opnd[1]), 32'h1111);
        chk("novld_sel", 32'(bus_if.fwd_sel[1]), 32'h0);

        // load-use: one bubble
        idle();
        load_use_in();
        cycle("lu");
        idle();
        cycle("lu_after");

        // mem_busy three cycles while WB value retires
        bus_if.mw_wr = 1'b1; bus_if.mw_dst = 3'd4; bus_if.mw_data = 16'h00AA;
        bus_if.ex_src[0] = 3'd4; bus_if.ex_src_vld = 2'b01; bus_if.mem_busy = 1'b1;
        cycle("busy0");
        bus_if.mw_wr = 1'b0;
        cycle("busy1");
        cycle("busy2");
        bus_if.mem_busy = 1'b0;
        cycle("busy_exit");
        chk("busy_ret_val", 32'(bus_if.ex_opnd[0]), 32'(bus_if.ex_rf_data[0]));
        cycle("busy_run");

        // load-use together with mem_busy, then re-evaluated after HOLD
        load_use_in();
        bus_if.mem_busy = 1'b1;
        cycle("lu_busy");
        bus_if.mem_busy = 1'b0;
        cycle("lu_busy_exit");
        cycle("lu_busy_rerun");
        idle();

        // reset in the middle of HOLD
        bus_if.mem_busy = 1'b1;
        cycle("rh_enter");
        cycle("rh_hold");
        rst_n = 1'b0;
        cycle("rh_reset");
        rst_n = 1'b1;
        bus_if.mem_busy = 1'b0;
        cycle("rh_run");

        // counter saturation
        load_use_in();
        for (int i = 0; i < 20; i++) cycle("sat");
`ifdef FWD_STATS_EN
        chk("sat_final", 32'(bus_if.stat_lu), 32'(CMAX));
`endif
        idle();

        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                bus_if.id_src[p]     = REG_AW'($urandom_range(0, 3));
                bus_if.ex_src[p]     = REG_AW'($urandom_range(0, 3));
                bus_if.ex_rf_data[p] = DATA_W'($urandom);
            end
            bus_if.id_src_vld = NPORTS'($urandom);
            bus_if.ex_src_vld = NPORTS'($urandom);
            bus_if.ex_dst     = REG_AW'($urandom_range(0, 3));
            bus_if.ex_wr      = 1'($urandom);
            bus_if.ex_mem_rd  = 1'($urandom);
            bus_if.em_dst     = REG_AW'($urandom_range(0, 3));
            bus_if.em_wr      = 1'($urandom);
            bus_if.em_mem_rd  = ($urandom_range(0, 3) == 0);
            bus_if.em_alu     = DATA_W'($urandom);
            bus_if.mw_dst     = REG_AW'($urandom_range(0, 3));
            bus_if.mw_wr      = 1'($urandom);
            bus_if.mw_data    = DATA_W'($urandom);
            bus_if.mem_busy   = ($urandom_range(0, 3) == 0);
            rst_n             = ($urandom_range(0, 39) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
